// File: rtl/watch_pkg.sv
// watch_pkg: mode encodings and debounce sizing shared by the button front end and the watch controller
package watch_pkg;
   localparam int MODE_W = 3;
   typedef enum logic [MODE_W-1:0] {
      WATCH     = 3'b000,
      STOPWATCH = 3'b001,
      ALARM     = 3'b010,
      DAY       = 3'b011
   } mode_t;
   function automatic int db_cnt_w(input int cycles);
      return $clog2(cycles);
   endfunction
   function automatic mode_t next_mode(input mode_t m);
      return m == DAY ? WATCH : mode_t'(m + 3'd1);
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter, debounced level and one-cycle press pulse
module btn_debounce
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam int W = db_cnt_w(DEBOUNCE_CYCLES);
   logic [1:0]   sync;
   logic [W-1:0] cnt;
   logic         level_q;
   logic         done;
   assign done = (sync[1] != level) && (cnt == W'(DEBOUNCE_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (reset) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync    <= {sync[0], raw};
         cnt     <= (sync[1] == level || done) ? '0 : cnt + W'(1);
         level   <= done ? sync[1] : level;
         level_q <= level;
         press   <= level & ~level_q;
      end
   end
endmodule

// File: rtl/watch_button_ctrl.sv
// watch_button_ctrl: debounced buttons to mode FSM, setValue and command pulses; WATCH_AUTOREPEAT_EN adds upTime hold-repeat
module watch_button_ctrl
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20
`ifdef WATCH_AUTOREPEAT_EN
   ,
   parameter int HOLD_CYCLES   = 500,
   parameter int REPEAT_CYCLES = 100
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_mode,
   input  logic              btn_set,
   input  logic              btn_reset,
   input  logic              btn_up,
   input  logic              btn_next,
   input  logic              btn_start,
   input  logic              btn_stop,
   output logic [MODE_W-1:0] mode,
   output logic              setValue,
   output logic              resetTime,
   output logic              upTime,
   output logic              nextd,
   output logic              start_resume,
   output logic              stop
);
   logic [5:0] raw, prs;
   logic       p_mode, p_set, p_reset, p_next, p_start, p_stop, p_up;
   logic       set_q, set_n, rep;
   mode_t      mode_q, mode_n;
   assign raw = {btn_stop, btn_start, btn_next, btn_reset, btn_set, btn_mode};
   assign {p_stop, p_start, p_next, p_reset, p_set, p_mode} = prs;
   for (genvar i = 0; i < 6; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .reset (reset),
         .raw   (raw[i]),
         .level (),
         .press (prs[i])
      );
   end
`ifdef WATCH_AUTOREPEAT_EN
   localparam int HW = $clog2(HOLD_CYCLES + 2);
   logic          up_lvl;
   logic [HW-1:0] hc;
   // hc starts one cycle after the level rises, so HOLD_CYCLES+1 lines the first repeat up HOLD_CYCLES after the initial pulse
   assign rep = hc == HW'(HOLD_CYCLES + 1);
   always_ff @(posedge clk) begin
      if (reset || !(up_lvl && set_q))
         hc <= '0;
      else
         hc <= rep ? HW'(HOLD_CYCLES + 2 - REPEAT_CYCLES) : hc + HW'(1);
   end
`else
   assign rep = 1'b0;
`endif
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_up),
`ifdef WATCH_AUTOREPEAT_EN
      .level (up_lvl),
`else
      .level (),
`endif
      .press (p_up)
   );
   always_comb begin
      set_n  = (p_set && mode_q != STOPWATCH) ? ~set_q : set_q;
      mode_n = (p_mode && !p_set && !set_q) ? next_mode(mode_q) : mode_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q       <= WATCH;
         set_q        <= 1'b0;
         resetTime    <= 1'b0;
         upTime       <= 1'b0;
         nextd        <= 1'b0;
         start_resume <= 1'b0;
         stop         <= 1'b0;
      end else begin
         mode_q       <= mode_n;
         set_q        <= set_n;
         resetTime    <= p_reset;
         upTime       <= set_q & (p_up | rep);
         nextd        <= set_q & p_next;
         start_resume <= ~set_q & p_start;
         stop         <= ~set_q & p_stop;
      end
   end
   assign mode     = mode_q;
   assign setValue = set_q;
endmodule

// File: tb/tb_watch_button_ctrl.sv
// tb_watch_button_ctrl: directed button presses with a scoreboard of expected output events
module tb_watch_button_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] btn = '0;
   logic [2:0] mode;
   logic       setValue, resetTime, upTime, nextd, start_resume, stop;
   logic [8:0] cur;
   logic [3:0] prev;
   logic [8:0] q[$];
   int         total = 0;
   int         bad = 0;
   int         exp_mode = 0;
   logic       exp_set = 1'b0;
   bit         mon_en = 1'b0;
   int         k;

   always #5 clk = ~clk;

   watch_button_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .btn_mode     (btn[0]),
      .btn_set      (btn[1]),
      .btn_reset    (btn[2]),
      .btn_up       (btn[3]),
      .btn_next     (btn[4]),
      .btn_start    (btn[5]),
      .btn_stop     (btn[6]),
      .mode         (mode),
      .setValue     (setValue),
      .resetTime    (resetTime),
      .upTime       (upTime),
      .nextd        (nextd),
      .start_resume (start_resume),
      .stop         (stop)
   );

   assign cur = {mode, setValue, resetTime, upTime, nextd, start_resume, stop};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [8:0] snap(input logic [4:0] p);
      logic [31:0] m;
      m = exp_mode;
      return {m[2:0], exp_set, p};
   endfunction

   // expected effect of one press, pulse bits are {resetTime, upTime, nextd, start_resume, stop}
   task automatic model(input int b);
      case (b)
         0: if (!exp_set) begin exp_mode = (exp_mode + 1) % 4; q.push_back(snap(5'b00000)); end
         1: if (exp_mode != 1) begin exp_set = ~exp_set; q.push_back(snap(5'b00000)); end
         2: q.push_back(snap(5'b10000));
         3: if (exp_set) q.push_back(snap(5'b01000));
         4: if (exp_set) q.push_back(snap(5'b00100));
         5: if (!exp_set) q.push_back(snap(5'b00010));
         6: if (!exp_set) q.push_back(snap(5'b00001));
         default: ;
      endcase
   endtask

   task automatic press(input int b);
      model(b);
      @(negedge clk) btn[b] = 1'b1;
      repeat (25) @(negedge clk);
      btn[b] = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   task automatic bounce_up();
      model(3);
      @(negedge clk) btn[3] = 1'b1;
      repeat (5) @(negedge clk);
      btn[3] = 1'b0;
      repeat (5) @(negedge clk);
      btn[3] = 1'b1;
      repeat (5) @(negedge clk);
      btn[3] = 1'b0;
      repeat (5) @(negedge clk);
      btn[3] = 1'b1;
      repeat (30) @(negedge clk);
      btn[3] = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (cur[4:0] != 5'b0 || cur[8:5] != prev) begin
            if (q.size() == 0)
               chk("unexpected_event", cur, {prev, 5'b0});
            else
               chk("event", cur, q.pop_front());
         end
         prev = cur[8:5];
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_mode", mode, 0);
      chk("reset_set", setValue, 0);
      chk("reset_pulses", cur[4:0], 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      prev = cur[8:5];
      mon_en = 1'b1;
      // first mode press: latency measured from the first sampling edge
      model(0);
      @(negedge clk) btn[0] = 1'b1;
      k = 0;
      while (k < 40 && mode !== 3'd1) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("mode_latency", k, 24);
      repeat (2) @(negedge clk);
      btn[0] = 1'b0;
      repeat (30) @(negedge clk);
      chk("mode_after_hold", mode, 1);
      press(0);
      chk("mode_alarm", mode, 2);
      press(0);
      chk("mode_day", mode, 3);
      press(0);
      chk("mode_wrap", mode, 0);
      // up presses dropped outside edit mode, one pulse inside it
      bounce_up();
      press(1);
      chk("watch_edit", setValue, 1);
      bounce_up();
      press(4);
      press(1);
      chk("watch_edit_off", setValue, 0);
      press(5);
      // ALARM edit mode blocks mode and start
      press(0);
      press(0);
      press(1);
      chk("alarm_edit", setValue, 1);
      press(0);
      chk("alarm_mode_held", mode, 2);
      press(5);
      press(2);
      press(1);
      chk("alarm_mode", mode, 2);
      chk("alarm_edit_off", setValue, 0);
      // STOPWATCH ignores set
      press(0);
      press(0);
      press(0);
      chk("stopwatch_mode", mode, 1);
      press(1);
      chk("stopwatch_no_edit", setValue, 0);
      press(5);
      press(6);
      // reset in the middle of a mode debounce
      @(negedge clk) btn[0] = 1'b1;
      repeat (10) @(negedge clk);
      if (exp_mode != 0 || exp_set) begin
         exp_mode = 0;
         exp_set = 1'b0;
         q.push_back(snap(5'b00000));
      end
      reset = 1'b1;
      btn[0] = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("reset_mid_mode", mode, 0);
      chk("reset_mid_set", setValue, 0);
      repeat (10) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
